// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver types and defaults for the 8N1 UART receiver
package uart_pkg;
  localparam int DATA_BITS = 8;
  localparam int DEF_CLK_FREQ_HZ = 100_000_000;
  localparam int DEF_BAUD = 115_200;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the asynchronous rx pin, resets to idle-high
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  logic meta;
  // shift the pin through two flops; reset to the idle line level
  always_ff @(posedge clk_i)
    if (!rst_i) {q_o, meta} <= 2'b11;
    else {q_o, meta} <= {meta, d_i};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with mid-bit sampling; UART_RX_SYNC_EN adds a two-flop input synchronizer
module uart_rx import uart_pkg::*; #(
  parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
  parameter int BAUD = DEF_BAUD,
  parameter int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       uart_rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_frame_err_o,
  output logic       rx_busy_o
);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  rx_state_t state;
  logic [CW-1:0] clk_cnt;
  logic [BW-1:0] bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic rx_s;
`ifdef UART_RX_SYNC_EN
  uart_rx_sync u_sync (.clk_i(clk_i), .rst_i(rst_i), .d_i(uart_rx_i), .q_o(rx_s));
`else
  assign rx_s = uart_rx_i;
`endif
  // frame FSM: start qualified at half a bit, data and stop sampled a full bit apart
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      shift <= '0;
      rx_data_o <= '0;
      rx_valid_o <= 1'b0;
      rx_frame_err_o <= 1'b0;
      rx_busy_o <= 1'b0;
    end else begin
      rx_valid_o <= 1'b0;
      rx_frame_err_o <= 1'b0;
      case (state)
        IDLE: if (!rx_s) begin
          state <= START;
          clk_cnt <= '0;
          rx_busy_o <= 1'b1;
        end
        START: if (clk_cnt == HALF_END) begin
          clk_cnt <= '0;
          bit_idx <= '0;
          state <= rx_s ? IDLE : DATA;
          rx_busy_o <= !rx_s;
        end else clk_cnt <= clk_cnt + 1'b1;
        DATA: if (clk_cnt == BIT_END) begin
          clk_cnt <= '0;
          shift[bit_idx] <= rx_s;
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == LAST_BIT) state <= STOP;
        end else clk_cnt <= clk_cnt + 1'b1;
        STOP: if (clk_cnt == BIT_END) begin
          clk_cnt <= '0;
          rx_valid_o <= rx_s;
          rx_frame_err_o <= !rx_s;
          rx_busy_o <= !rx_s;
          state <= rx_s ? IDLE : WAIT_HIGH;
          if (rx_s) rx_data_o <= shift;
        end else clk_cnt <= clk_cnt + 1'b1;
        WAIT_HIGH: if (rx_s) begin
          state <= IDLE;
          rx_busy_o <= 1'b0;
        end
        default: begin
          state <= IDLE;
          rx_busy_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven and random frames checked against a cycle-indexed behavioural receiver model
module tb_uart_rx;
  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD_R = 100_000;
  localparam int CPB = CLK_HZ / BAUD_R;
  localparam int HALF = CPB / 2;
`ifdef UART_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int MAXN = 8192;

  logic clk = 1'b0;
  logic rst_i = 1'b0;
  logic uart_rx_i = 1'b1;
  logic [7:0] rx_data_o;
  logic rx_valid_o, rx_frame_err_o, rx_busy_o;

  always #5 clk = ~clk;

  uart_rx #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD_R)) dut (
    .clk_i(clk), .rst_i(rst_i), .uart_rx_i(uart_rx_i), .rx_data_o(rx_data_o),
    .rx_valid_o(rx_valid_o), .rx_frame_err_o(rx_frame_err_o), .rx_busy_o(rx_busy_o)
  );

  typedef struct {
    logic [7:0] d;
    bit stop;
    int tail;
    int gap;
    bit seg_end;
    bit exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  int total = 0;
  int bad = 0;
  int n = 0;
  bit ln [MAXN];
  bit ov [MAXN], oe [MAXN], ob [MAXN];
  logic [7:0] od [MAXN];
  bit ev [MAXN], ee [MAXN], eb [MAXN];
  logic [7:0] ed [MAXN], evb [MAXN];
  logic [7:0] mdat = 8'h00;
  logic [7:0] last_good = 8'h00;
  logic [7:0] vq [$];
  logic [7:0] eq [$];
  int last_vi [$];
  int last_busy = 0;
  vec_t tbl [6];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // one clock of line stimulus; records what the DUT showed after the previous edge
  task automatic tick(input bit v);
    @(negedge clk);
    if (n > 0 && n <= MAXN) begin
      ov[n-1] = rx_valid_o;
      oe[n-1] = rx_frame_err_o;
      ob[n-1] = rx_busy_o;
      od[n-1] = rx_data_o;
    end
    uart_rx_i = v;
    if (n < MAXN) ln[n] = v;
    n++;
  endtask

  task automatic send(input logic [7:0] d, input bit stop, input int tail, input int gap);
    repeat (CPB) tick(1'b0);
    for (int i = 0; i < 8; i++) repeat (CPB) tick(d[i]);
    repeat (CPB) tick(stop);
    repeat (tail) tick(1'b0);
    repeat (gap) tick(1'b1);
  endtask

  function automatic bit s(input int k);
    return (k < LAT) ? 1'b1 : ln[k-LAT];
  endfunction

  // receiver semantics over the recorded line: start qualified HALF after the first low
  // sample, bit i taken (i+1) bit periods later, stop after nine periods
  task automatic predict(input int nn);
    int k, c, m, t, j;
    logic [7:0] b, cur;
    for (int i = 0; i < nn; i++) begin
      ev[i] = 0;
      ee[i] = 0;
      eb[i] = 0;
    end
    k = 0;
    while (k < nn) begin
      if (s(k)) k++;
      else begin
        c = k;
        m = c + HALF;
        t = m + 9 * CPB;
        if (m >= nn || (!s(m) && t >= nn)) begin
          for (int i = c; i < nn; i++) eb[i] = 1;
          k = nn;
        end else if (s(m)) begin
          for (int i = c; i < m; i++) eb[i] = 1;
          k = m + 1;
        end else begin
          for (int i = 0; i < 8; i++) b[i] = s(m + (i + 1) * CPB);
          if (s(t)) begin
            for (int i = c; i < t; i++) eb[i] = 1;
            ev[t] = 1;
            evb[t] = b;
            k = t + 1;
          end else begin
            ee[t] = 1;
            j = t + 1;
            while (j < nn && !s(j)) j++;
            for (int i = c; i < j && i < nn; i++) eb[i] = 1;
            k = j + 1;
          end
        end
      end
    end
    cur = mdat;
    for (int i = 0; i < nn; i++) begin
      if (ev[i]) cur = evb[i];
      ed[i] = cur;
    end
    mdat = cur;
  endtask

  task automatic check_seg(input string tag);
    int no, mv, me, mb, md, nb;
    logic [7:0] vb [$];
    logic [7:0] xb [$];
    int vi [$];
    chk({tag, "_len_ok"}, int'(n <= MAXN), 1);
    no = ((n > MAXN) ? MAXN : n) - 1;
    predict(no + 1);
    mv = 0; me = 0; mb = 0; md = 0; nb = 0;
    for (int k = 0; k < no; k++) begin
      if (ov[k] != ev[k]) mv++;
      if (oe[k] != ee[k]) me++;
      if (ob[k] != eb[k]) mb++;
      if (od[k] !== ed[k]) md++;
      if (ov[k]) begin
        vi.push_back(k);
        vb.push_back(od[k]);
      end
      if (oe[k]) xb.push_back(od[k]);
      if (ob[k]) nb++;
    end
    chk({tag, "_valid_trace_mismatches"}, mv, 0);
    chk({tag, "_err_trace_mismatches"}, me, 0);
    chk({tag, "_busy_trace_mismatches"}, mb, 0);
    chk({tag, "_data_trace_mismatches"}, md, 0);
    chk({tag, "_valid_count"}, vb.size(), vq.size());
    for (int i = 0; i < vb.size() && i < vq.size(); i++) chk({tag, "_valid_data"}, vb[i], vq[i]);
    chk({tag, "_err_count"}, xb.size(), eq.size());
    for (int i = 0; i < xb.size() && i < eq.size(); i++) chk({tag, "_err_data_held"}, xb[i], eq[i]);
    last_vi = vi;
    last_busy = nb;
    n = 0;
    vq.delete();
    eq.delete();
  endtask

  initial begin
    tbl[0] = '{8'h55, 1'b1, 0, CPB * 3 / 2, 1'b0, 1'b1, 8'h55};
    tbl[1] = '{8'h55, 1'b1, 0, 40, 1'b1, 1'b1, 8'h55};
    tbl[2] = '{8'h00, 1'b1, 0, 0, 1'b0, 1'b1, 8'h00};
    tbl[3] = '{8'hFF, 1'b1, 0, 40, 1'b1, 1'b1, 8'hFF};
    tbl[4] = '{8'hA5, 1'b0, 5 * CPB, 40, 1'b0, 1'b0, 8'h00};
    tbl[5] = '{8'h3C, 1'b1, 0, 40, 1'b1, 1'b1, 8'h3C};

    repeat (3) @(negedge clk);
    chk("reset_data", rx_data_o, 0);
    chk("reset_valid", rx_valid_o, 0);
    chk("reset_err", rx_frame_err_o, 0);
    chk("reset_busy", rx_busy_o, 0);
    rst_i = 1'b1;

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].exp_valid) begin
        vq.push_back(tbl[i].exp_data);
        last_good = tbl[i].exp_data;
      end else eq.push_back(last_good);
      send(tbl[i].d, tbl[i].stop, tbl[i].tail, tbl[i].gap);
      if (tbl[i].seg_end) begin
        check_seg($sformatf("row%0d", i));
        if (i == 1) begin
          chk("first_latency", (last_vi.size() > 0) ? last_vi[0] : -1, LAT + HALF + 9 * CPB);
          chk("pair_spacing", (last_vi.size() == 2) ? last_vi[1] - last_vi[0] : -1, 10 * CPB + CPB * 3 / 2);
        end
      end
    end

    repeat (2) tick(1'b0);
    repeat (HALF + 40) tick(1'b1);
    check_seg("glitch");
    chk("glitch_busy_short", int'(last_busy > 0 && last_busy <= HALF + 1), 1);

    repeat (CPB) tick(1'b0);
    repeat (CPB) tick(1'b0);
    repeat (CPB) tick(1'b1);
    repeat (CPB) tick(1'b0);
    check_seg("abort");
    @(negedge clk);
    rst_i = 1'b0;
    uart_rx_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_data", rx_data_o, 0);
    chk("midrst_valid", rx_valid_o, 0);
    chk("midrst_err", rx_frame_err_o, 0);
    chk("midrst_busy", rx_busy_o, 0);
    rst_i = 1'b1;
    mdat = 8'h00;
    last_good = 8'h00;
    vq.push_back(8'h81);
    last_good = 8'h81;
    send(8'h81, 1'b1, 0, 40);
    check_seg("after_rst");

    for (int r = 0; r < 20; r++) begin
      logic [7:0] d;
      int ch;
      d = 8'($urandom);
      ch = $urandom_range(0, 9);
      if (ch == 0) begin
        repeat ($urandom_range(1, HALF - 1)) tick(1'b0);
        repeat (HALF + 2 + $urandom_range(0, 10)) tick(1'b1);
      end else if (ch < 3) begin
        eq.push_back(last_good);
        send(d, 1'b0, $urandom_range(0, 3 * CPB), $urandom_range(2, 30));
      end else begin
        vq.push_back(d);
        last_good = d;
        send(d, 1'b1, 0, $urandom_range(0, 30));
      end
    end
    repeat (40) tick(1'b1);
    check_seg("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Fixed-baud asynchronous serial receiver: 8 data bits, no parity, 1 stop bit (8N1), LSB first.
- Oversamples the `uart_rx_i` line with the system clock, samples each bit at mid-bit, and presents each received byte with a one-cycle valid strobe.
- Sits between the board RX pin and the on-chip consumer (register file or FIFO); the consumer has no back-pressure.

Parameters:
- CLK_FREQ_HZ, 100000000, system clock frequency.
- BAUD, 115200, line bit rate.
- CLKS_PER_BIT, CLK_FREQ_HZ/BAUD (868), clocks per bit, integer-truncated; legal range ≥ 4.

Ports:
- clk_i  in  1  system clock; all logic on the rising edge.
- rst_i  in  1  reset, synchronous, active-low (0 = reset).
- uart_rx_i  in  1  serial line; idle high.
- rx_data_o  out  8  last correctly framed byte.
- rx_valid_o  out  1  one-cycle pulse; `rx_data_o` is new in this cycle.
- rx_frame_err_o  out  1  one-cycle pulse; stop bit sampled low.
- rx_busy_o  out  1  high while a frame is being received (any state other than IDLE).

Behaviour:
- Reset (`rst_i` = 0 at a clock edge):
  - state = IDLE; bit and clock counters = 0; shift register = 0.
  - `rx_data_o` = 0x00; `rx_valid_o`, `rx_frame_err_o` and `rx_busy_o` = 0.
  - Reset mid-frame abandons the frame; no pulses are produced.
- HALF = CLKS_PER_BIT/2, which is 434 at the default parameters.
- Clock-counter width = $clog2(CLKS_PER_BIT).
- States:
  - IDLE: when the sampled line is 0 → START, clock counter = 0.
  - START:
    - Count to HALF-1.
    - At that point, line still 0 → DATA with counters cleared.
    - Line 1 → false start, back to IDLE, no pulse.
  - DATA:
    - Every CLKS_PER_BIT clocks, sample the line into shift-register bit [bit_idx], LSB first.
    - After bit 7 → STOP.
  - STOP:
    - After CLKS_PER_BIT clocks, sample the line.
    - Line = 1: `rx_data_o` ← shift register; `rx_valid_o` = 1 for exactly one cycle; → IDLE.
    - Line = 0: `rx_frame_err_o` = 1 for one cycle; `rx_data_o` is unchanged; → WAIT_HIGH.
  - WAIT_HIGH: stay until the sampled line is 1, then → IDLE. A held-low line (break) produces only one error.
- Return to IDLE happens at the middle of the stop bit, so a start bit immediately following the stop bit is caught.
- Latency: `rx_valid_o` asserts HALF + 9·CLKS_PER_BIT (+ synchronizer delay) clocks after the start-bit falling edge.
- `rx_valid_o` and `rx_frame_err_o` are never high in the same cycle.
- Outputs are registered.

Optional Feature:
- Macro UART_RX_SYNC_EN.
- Defined: `uart_rx_i` passes through a two-flop synchronizer, reset to 1, before all logic. This adds 2 cycles of latency to every event.
- Undefined: `uart_rx_i` is used directly, and must be driven from synchronous logic.
- Functional results are identical apart from the 2-cycle shift.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, START, DATA, STOP, WAIT_HIGH);
  - DATA_BITS = 8;
  - default CLK_FREQ_HZ and BAUD.
- One sub-module, uart_rx_sync: two-flop synchronizer, instantiated only under UART_RX_SYNC_EN.
- Baud counting stays inline.

Test Plan:
- Byte 0x55 at 8680 ns/bit with a 10 ns clock (start 0; data 1,0,1,0,1,0,1,0; stop 1) → exactly one `rx_valid_o` pulse with `rx_data_o` = 0x55; no `rx_frame_err_o`.
- Two 0x55 frames separated by 1.5 idle bits → two `rx_valid_o` pulses, each with 0x55, spaced by the frame period.
- Byte 0x00, then 0xFF, start bit directly after the previous stop bit → valid pulses with 0x00, then 0xFF.
- Low glitch of 1000 ns on an idle line → no `rx_valid_o`, no `rx_frame_err_o`; `rx_busy_o` returns to 0 within HALF+1 clocks.
- Frame 0xA5 with stop bit = 0 → one `rx_frame_err_o` pulse; `rx_data_o` keeps its previous value; line held low for 5 bit times gives no second error; the next good frame 0x3C → valid pulse with 0x3C.
- `rst_i` driven low mid-DATA for 3 clocks, then a clean 0x81 frame → no pulse from the aborted frame; valid pulse with 0x81.
